// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path.
// No logic and no latency. Holds state encodings, opcodes, ALUOP codes and mux selects.
package riscv_ctrl_pkg;

    localparam int OPW  = 7;
    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11
`else
        S_BRANCH   = 4'd10
`endif
    } state_t;

    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPW-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;

    // Moore control word; pc_write is assembled separately because it mixes in taken.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] aluop;
        logic       instr_retired;
    } ctrl_t;

    function automatic logic [1:0] imm_sel(input logic [OPW-1:0] op);
        case (op)
            OP_LOAD, OP_ITYPE: imm_sel = IMM_I;
            OP_STORE:          imm_sel = IMM_S;
            OP_BRANCH:         imm_sel = IMM_B;
            OP_JAL:            imm_sel = IMM_J;
            default:           imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_branch_eval.sv
// Branch condition evaluator: beq/bne/blt decided from ALU flags.
// Purely combinational, zero latency. No handshake, no backpressure.
module riscv_branch_eval
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       alu_neg,
    output logic       taken
);

    always_comb begin
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = alu_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Multicycle RISC-V main control FSM (lw/sw/R/I/jal/beq/bne/blt); RISCV_CTRL_ILLEGAL_TRAP_EN adds a HALT trap.
// Zero-wait latency: lw 5, sw 4, R/I 4, jal 4, branch 3 cycles. Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready.
module riscv_multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic [2:0]     funct3,
    input  logic           zero,
    input  logic           alu_neg,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           adr_src,
    output logic           ir_write,
    output logic           pc_write,
    output logic           reg_write,
    output logic [1:0]     alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     result_src,
    output logic [1:0]     imm_src,
    output logic [1:0]     ALUOP,
    output logic           instr_retired,
    output logic           illegal
);

    state_t state;
    state_t state_nxt;
    ctrl_t  c;
    ctrl_t  q;
    logic   pc_update;
    logic   branch;
    logic   taken;

    riscv_branch_eval u_branch_eval (
        .funct3  (funct3),
        .zero    (zero),
        .alu_neg (alu_neg),
        .taken   (taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        c         = '0;
        c.imm_src = imm_sel(opcode);
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.adr_src    = ADR_PC;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.aluop      = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                // IR load and PC+4 happen only on the completing cycle, so a stall never double-increments.
                c.ir_write   = mem_ready;
                pc_update    = mem_ready;
                state_nxt    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_BRANCH:         state_nxt = S_BRANCH;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
                    default:           state_nxt = S_HALT;
`else
                    default: begin
                        state_nxt       = S_FETCH;
                        c.instr_retired = 1'b1;
                    end
`endif
                endcase
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
                state_nxt   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                c.mem_req    = 1'b1;
                c.adr_src    = ADR_ALUOUT;
                c.result_src = RES_ALUOUT;
                state_nxt    = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                c.result_src    = RES_DATA;
                c.reg_write     = 1'b1;
                c.instr_retired = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_MEMWRITE: begin
                c.mem_req       = 1'b1;
                c.mem_we        = 1'b1;
                c.adr_src       = ADR_ALUOUT;
                c.result_src    = RES_ALUOUT;
                c.instr_retired = mem_ready;
                state_nxt       = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_REGB;
                c.aluop     = ALUOP_FUNCT;
                state_nxt   = S_ALUWB;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_FUNCT;
                state_nxt   = S_ALUWB;
            end
            S_JAL: begin
                // Target was computed into ALUOut during DECODE; ALU now forms OldPC+4 for the link.
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.aluop      = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                pc_update    = 1'b1;
                state_nxt    = S_ALUWB;
            end
            S_ALUWB: begin
                c.result_src    = RES_ALUOUT;
                c.reg_write     = 1'b1;
                c.instr_retired = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a     = SRCA_REGA;
                c.alu_src_b     = SRCB_REGB;
                c.aluop         = ALUOP_BRANCH;
                c.result_src    = RES_ALUOUT;
                branch          = 1'b1;
                c.instr_retired = 1'b1;
                state_nxt       = S_FETCH;
            end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
            S_HALT: begin
                c         = '0;
                state_nxt = S_HALT;
            end
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // Reset forces every output low even though the state already reads FETCH.
    assign q             = rst ? '0 : c;
    assign mem_req       = q.mem_req;
    assign mem_we        = q.mem_we;
    assign adr_src       = q.adr_src;
    assign ir_write      = q.ir_write;
    assign reg_write     = q.reg_write;
    assign alu_src_a     = q.alu_src_a;
    assign alu_src_b     = q.alu_src_b;
    assign result_src    = q.result_src;
    assign imm_src       = q.imm_src;
    assign ALUOP         = q.aluop;
    assign instr_retired = q.instr_retired;
    assign pc_write      = ~rst & (pc_update | (branch & taken));

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    assign illegal = ~rst & (state == S_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Self-checking bench for riscv_multicycle_controller: per-cycle output vectors against an instruction-level model.
// Honours RISCV_CTRL_ILLEGAL_TRAP_EN for the unknown-opcode scenario.
module tb_riscv_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       alu_neg = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, ALUOP;
    logic       instr_retired, illegal;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ir_pulses = 0;
    int pcw_pulses = 0;
    int retire_at[$];

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0001111;

    typedef struct packed {
        logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] src_a, src_b, res, imm, aluop;
        logic       ret, ill;
    } obs_t;

    typedef enum {PH_F, PH_D, PH_MA, PH_MR, PH_MWB, PH_MW, PH_ER, PH_EI, PH_J, PH_AWB, PH_BR, PH_HALT} phase_e;
    typedef struct {
        phase_e ph;
        logic   rdy;
    } step_t;

    riscv_multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .alu_neg(alu_neg),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src), .ALUOP(ALUOP),
        .instr_retired(instr_retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.mem_req = mem_req;   o.mem_we = mem_we;       o.adr_src = adr_src;
        o.ir_write = ir_write; o.pc_write = pc_write;   o.reg_write = reg_write;
        o.src_a = alu_src_a;   o.src_b = alu_src_b;     o.res = result_src;
        o.imm = imm_src;       o.aluop = ALUOP;         o.ret = instr_retired;
        o.ill = illegal;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        return op inside {LW, SW, RT, IT, JL, BR};
    endfunction

    // Expected outputs for one cycle of a given instruction phase, straight from the control table.
    function automatic obs_t exp_vec(input phase_e ph, input logic rdy, input logic [6:0] op,
                                     input logic [2:0] f3, input logic z, input logic n);
        obs_t e = '0;
        logic tk;
        tk = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && n);
        if (op == SW)      e.imm = 2'd1;
        else if (op == BR) e.imm = 2'd2;
        else if (op == JL) e.imm = 2'd3;
        case (ph)
            PH_F:   begin e.mem_req = 1; e.src_b = 2'd2; e.res = 2'd2; e.ir_write = rdy; e.pc_write = rdy; end
            PH_D:   begin
                e.src_a = 2'd1; e.src_b = 2'd1;
`ifndef RISCV_CTRL_ILLEGAL_TRAP_EN
                e.ret = !known_op(op);
`endif
            end
            PH_MA:  begin e.src_a = 2'd2; e.src_b = 2'd1; end
            PH_MR:  begin e.mem_req = 1; e.adr_src = 1; end
            PH_MWB: begin e.res = 2'd1; e.reg_write = 1; e.ret = 1; end
            PH_MW:  begin e.mem_req = 1; e.mem_we = 1; e.adr_src = 1; e.ret = rdy; end
            PH_ER:  begin e.src_a = 2'd2; e.aluop = 2'd2; end
            PH_EI:  begin e.src_a = 2'd2; e.src_b = 2'd1; e.aluop = 2'd2; end
            PH_J:   begin e.src_a = 2'd1; e.src_b = 2'd2; e.pc_write = 1; end
            PH_AWB: begin e.reg_write = 1; e.ret = 1; end
            PH_BR:  begin e.src_a = 2'd2; e.aluop = 2'd1; e.pc_write = tk; e.ret = 1; end
            PH_HALT: begin e = '0; e.ill = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Runs one instruction from its fetch; called and returns at a falling edge. max_cyc<0 runs to completion.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic n,
                             input int fw, input int mw, input int max_cyc);
        step_t plan[$];
        obs_t  act, exp;
        for (int i = 0; i < fw; i++) plan.push_back('{PH_F, 1'b0});
        plan.push_back('{PH_F, 1'b1});
        plan.push_back('{PH_D, rbit()});
        case (op)
            LW: begin
                plan.push_back('{PH_MA, rbit()});
                for (int i = 0; i < mw; i++) plan.push_back('{PH_MR, 1'b0});
                plan.push_back('{PH_MR, 1'b1});
                plan.push_back('{PH_MWB, rbit()});
            end
            SW: begin
                plan.push_back('{PH_MA, rbit()});
                for (int i = 0; i < mw; i++) plan.push_back('{PH_MW, 1'b0});
                plan.push_back('{PH_MW, 1'b1});
            end
            RT: begin plan.push_back('{PH_ER, rbit()}); plan.push_back('{PH_AWB, rbit()}); end
            IT: begin plan.push_back('{PH_EI, rbit()}); plan.push_back('{PH_AWB, rbit()}); end
            JL: begin plan.push_back('{PH_J, rbit()});  plan.push_back('{PH_AWB, rbit()}); end
            BR: plan.push_back('{PH_BR, rbit()});
            default: begin
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++) plan.push_back('{PH_HALT, rbit()});
`endif
            end
        endcase
        for (int k = 0; k < plan.size(); k++) begin
            if (max_cyc >= 0 && k >= max_cyc) break;
            opcode = op; funct3 = f3; zero = z; alu_neg = n; mem_ready = plan[k].rdy;
            #1;
            cyc++;
            act = sample();
            exp = exp_vec(plan[k].ph, plan[k].rdy, op, f3, z, n);
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL step op=%b f3=%b phase=%s cyc=%0d got=%h want=%h",
                         op, f3, plan[k].ph.name(), cyc, act, exp);
            end
            if (act.ir_write) ir_pulses++;
            if (act.pc_write) pcw_pulses++;
            if (act.ret) retire_at.push_back(cyc);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        obs_t act, exp;
        #1;
        n_cmp++;
        if (sample() !== '0) begin n_bad++; $display("FAIL reset_init got=%h want=0", sample()); end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        run_instr(SW, 3'd2, 1'b0, 1'b0, 0, 5, 5);   // parked in MEMWRITE wait
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sample() !== '0) begin n_bad++; $display("FAIL reset_mid_sw got=%h want=0", sample()); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (sample() !== '0) begin n_bad++; $display("FAIL reset_held got=%h want=0", sample()); end
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        act = sample();
        exp = exp_vec(PH_F, 1'b0, SW, 3'd2, 1'b0, 1'b0);
        n_cmp++;
        if (act !== exp) begin n_bad++; $display("FAIL reset_release_fetch got=%h want=%h", act, exp); end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_mem got req=%b we=%b want req=1 we=0", mem_req, mem_we);
        end
        @(negedge clk);
        cyc = 0;
        run_instr(IT, 3'd0, 1'b0, 1'b0, 0, 0, -1);
    endtask

    task automatic test_zero_wait_sequence();
        int want[4] = '{4, 9, 13, 16};
        int got;
        do_reset();
        retire_at.delete();
        run_instr(RT, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        run_instr(LW, 3'd2, 1'b0, 1'b0, 0, 0, -1);
        run_instr(SW, 3'd2, 1'b0, 1'b0, 0, 0, -1);
        run_instr(BR, 3'd0, 1'b1, 1'b0, 0, 0, -1);
        for (int i = 0; i < 4; i++) begin
            got = (i < retire_at.size()) ? retire_at[i] : -1;
            n_cmp++;
            if (got !== want[i]) begin n_bad++; $display("FAIL retire_cycle[%0d] got=%0d want=%0d", i, got, want[i]); end
        end
    endtask

    task automatic test_fetch_stall();
        do_reset();
        ir_pulses = 0;
        pcw_pulses = 0;
        retire_at.delete();
        run_instr(RT, 3'd0, 1'b0, 1'b0, 3, 0, -1);
        n_cmp++;
        if (ir_pulses !== 1) begin n_bad++; $display("FAIL stall_ir_write got=%0d want=1", ir_pulses); end
        n_cmp++;
        if (pcw_pulses !== 1) begin n_bad++; $display("FAIL stall_pc_write got=%0d want=1", pcw_pulses); end
        n_cmp++;
        if (retire_at.size() != 1 || retire_at[0] != 7) begin
            n_bad++; $display("FAIL stall_latency got=%0d retires want one at cycle 7", retire_at.size());
        end
    endtask

    task automatic test_branches();
        logic [4:0] cases[4] = '{5'b000_1_0, 5'b001_1_0, 5'b100_0_1, 5'b010_1_1};
        logic [4:0] c;
        for (int i = 0; i < 4; i++) begin
            c = cases[i];
            run_instr(BR, c[4:2], c[1], c[0], 0, 0, -1);
        end
    endtask

    task automatic test_jal();
        pcw_pulses = 0;
        run_instr(JL, 3'd5, 1'b1, 1'b0, 1, 0, -1);
        n_cmp++;
        if (pcw_pulses !== 2) begin n_bad++; $display("FAIL jal_pc_writes got=%0d want=2", pcw_pulses); end
    endtask

    task automatic test_illegal();
        do_reset();
        retire_at.delete();
        run_instr(BAD, 3'd0, 1'b0, 1'b0, 0, 0, -1);
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        n_cmp++;
        if (retire_at.size() != 0) begin n_bad++; $display("FAIL illegal_retire got=%0d want=0", retire_at.size()); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_clear got=%b want=0", illegal); end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
`else
        n_cmp++;
        if (retire_at.size() != 1 || retire_at[0] != 2) begin
            n_bad++; $display("FAIL nop_retire got=%0d retires want one at cycle 2", retire_at.size());
        end
`endif
        run_instr(RT, 3'd0, 1'b0, 1'b0, 0, 0, -1);
    endtask

    task automatic test_back_to_back_random();
        logic [6:0] ops[7] = '{LW, SW, RT, IT, JL, BR, BAD};
        int hi;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        hi = 5;
`else
        hi = 6;
`endif
        do_reset();
        for (int i = 0; i < 60; i++) begin
            run_instr(ops[$urandom_range(0, hi)], 3'($urandom_range(0, 7)), rbit(), rbit(),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_sequence();
        test_fetch_stall();
        test_branches();
        test_jal();
        test_illegal();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Main control FSM for the multicycle RISC-V core.
- Sequences the datapath through fetch, decode, execute, memory and writeback, and drives the 2-bit ALUOP consumed by the ALU control decoder.
- Supports lw, sw, R-type, I-type ALU, jal, and beq/bne/blt.
- Stalls on a memory ready handshake and emits a retire pulse per completed instruction.

Parameters:
- OPW, 7, opcode width (fixed by ISA, kept as a named constant).
- ST_W, 4, state register width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction[6:0] from IR; valid from DECODE onward
- funct3  in  3  instruction[14:12] from IR
- zero  in  1  ALU result == 0
- alu_neg  in  1  ALU result sign bit (for blt)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  PC register enable
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RegA
- alu_src_b  out  2  00 RegB, 01 ImmExt, 10 constant 4
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- ALUOP  out  2  00 add, 01 branch, 10 R/I-type
- instr_retired  out  1  one-cycle pulse on instruction completion
- illegal  out  1  illegal opcode flag (see Optional Feature)

Behaviour:
- Reset: state <= FETCH asynchronously.
  - While rst=1, all outputs are 0.
  - The first fetch begins on the first clk edge after rst deasserts.
- Outputs are Moore-decoded from state. Exceptions: pc_write, and the mem_ready gating described below.
- Unlisted outputs are 0.
- imm_src is decoded from opcode in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, others -> 00.
- pc_write = pc_update | (branch & taken). taken is determined by funct3:
  - 000: zero
  - 001: ~zero
  - 100: alu_neg
  - else: 0
- State outputs and transitions:
  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ALUOP=00, result_src=10.
    - ir_write and pc_update are asserted only when mem_ready=1.
    - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
    - Exactly one PC increment per fetch, whatever the stall length.
  - DECODE: alu_src_a=01, alu_src_b=01, ALUOP=00 (computes the branch/jal target). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - anything else -> illegal handling
  - MEMADR: alu_src_a=10, alu_src_b=01, ALUOP=00. Goes to MEMREAD if opcode[5]=0, MEMWRITE if opcode[5]=1.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00. Goes to MEMWB on mem_ready; otherwise holds.
  - MEMWB: result_src=01, reg_write=1, instr_retired=1 -> FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, adr_src=1, result_src=00.
    - On mem_ready: instr_retired=1 -> FETCH. Otherwise holds.
    - Exactly one write completes per sw.
  - EXECR: alu_src_a=10, alu_src_b=00, ALUOP=10 -> ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, ALUOP=10 -> ALUWB.
  - JAL: alu_src_a=01, alu_src_b=10, ALUOP=00, result_src=00, pc_update=1 -> ALUWB. The PC takes the target and ALUOut captures OldPC+4.
  - ALUWB: result_src=00, reg_write=1, instr_retired=1 -> FETCH.
  - BRANCH: alu_src_a=10, alu_src_b=00, ALUOP=01, result_src=00, branch=1, instr_retired=1 -> FETCH.
- Latency in cycles, with zero-wait memory:
  - lw 5, sw 4, R/I 4, jal 4, branch 3.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to FETCH, no partial writes.
- Undefined state encodings -> FETCH.

Optional Feature:
- Macro: RISCV_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> HALT state.
  - illegal=1 and all other outputs are 0.
  - HALT is left only by rst.
- Undefined: an unknown opcode is a NOP. DECODE -> FETCH with instr_retired=1. illegal is tied to 0 and the HALT state does not exist.

Decomposition:
- Shared package (riscv_ctrl_pkg) holds:
  - state encodings
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH
  - ALUOP constants
  - mux-select localparams
- One combinational sub-module, riscv_branch_eval: takes funct3, zero and alu_neg, and produces taken.

Test Plan:
- Reset: rst=1 mid-MEMWRITE, then release -> all outputs 0 during reset; state FETCH; mem_req=1 on the next cycle; no mem_we.
- Zero-wait sequence add, lw, sw, beq (mem_ready=1 always) -> state visits in order. Retire pulses at cycles 4, 9, 13, 16. ALUOP=10 in EXECR.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH -> ir_write and pc_write remain 0 until the ready cycle, then each pulses exactly once.
- Branches: beq with zero=1 -> pc_write=1 in BRANCH; bne with zero=1 -> pc_write=0; blt with alu_neg=1 -> pc_write=1; funct3=010 -> pc_write=0.
- jal: opcode 1101111 -> pc_write=1 in JAL; reg_write=1 with result_src=00 in the next cycle; imm_src=11.
- Opcode 0001111 in DECODE:
  - with RISCV_CTRL_ILLEGAL_TRAP_EN -> illegal=1 and held through 10 cycles, cleared by rst.
  - without it -> FETCH next cycle with instr_retired=1.
